// File: rtl/sweep_scheduler.sv
// Paces the sandpile simulation: speed-dependent wait, then a raster sweep of the N x N grid.
// Optional generation counter is enabled by defining SWEEP_GEN_COUNT_EN.
module sweep_scheduler #(
  parameter int RES_W    = 9,
  parameter int SPEED_W  = 12,
  parameter int PRESCALE = 1000,
  parameter int GEN_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active_i,
  input  logic [RES_W-1:0]   resolution_i,
  input  logic [SPEED_W-1:0] speed_i,
  output logic               cell_valid_o,
  input  logic               cell_ready_i,
  output logic [RES_W-1:0]   cell_x_o,
  output logic [RES_W-1:0]   cell_y_o,
  output logic               cell_last_o,
  output logic [GEN_W-1:0]   generation_o,
  output logic               busy_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SWEEP} state_t;

  state_t             state_reg, state_next;
  logic [PRE_W-1:0]   pre_cnt_reg;
  logic [SPEED_W-1:0] ivl_cnt_reg;
  logic [RES_W-1:0]   res_q_reg;
  logic [RES_W-1:0]   x_reg, y_reg;
  logic [RES_W-1:0]   res_last;
  logic               x_at_end, at_last, xfer, last_xfer, pre_tick;

  assign res_last  = res_q_reg - RES_W'(1);
  assign x_at_end  = (x_reg == res_last);
  assign at_last   = x_at_end && (y_reg == res_last);
  assign pre_tick  = (pre_cnt_reg == '0);
  assign xfer      = (state_reg == ST_SWEEP) && cell_ready_i;
  assign last_xfer = xfer && at_last;

  assign cell_valid_o = (state_reg == ST_SWEEP);
  assign cell_last_o  = (state_reg == ST_SWEEP) && at_last;
  assign cell_x_o     = x_reg;
  assign cell_y_o     = y_reg;
  assign busy_o       = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (game_active_i) state_next = ST_WAIT;
      // Losing the run enable aborts the countdown before it can start a sweep.
      ST_WAIT: begin
        if (!game_active_i)                        state_next = ST_IDLE;
        else if (pre_tick && ivl_cnt_reg == '0)    state_next = ST_SWEEP;
      end
      ST_SWEEP: if (last_xfer) state_next = game_active_i ? ST_WAIT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pre_cnt_reg <= '0;
      ivl_cnt_reg <= '0;
      res_q_reg   <= RES_W'(1);
      x_reg       <= '0;
      y_reg       <= '0;
    end else begin
      state_reg <= state_next;

      if (state_next == ST_WAIT && state_reg != ST_WAIT) begin
        pre_cnt_reg <= PRE_LOAD;
        ivl_cnt_reg <= speed_i;
      end else if (state_reg == ST_WAIT) begin
        if (pre_tick) begin
          pre_cnt_reg <= PRE_LOAD;
          if (ivl_cnt_reg != '0) ivl_cnt_reg <= ivl_cnt_reg - SPEED_W'(1);
        end else begin
          pre_cnt_reg <= pre_cnt_reg - PRE_W'(1);
        end
      end

      // Coordinates return to 0 after the final cell so idle/wait outputs read as zero.
      if (state_reg == ST_WAIT && state_next == ST_SWEEP) begin
        res_q_reg <= (resolution_i == '0) ? RES_W'(1) : resolution_i;
        x_reg     <= '0;
        y_reg     <= '0;
      end else if (xfer) begin
        if (at_last) begin
          x_reg <= '0;
          y_reg <= '0;
        end else if (x_at_end) begin
          x_reg <= '0;
          y_reg <= y_reg + RES_W'(1);
        end else begin
          x_reg <= x_reg + RES_W'(1);
        end
      end
    end
  end

`ifdef SWEEP_GEN_COUNT_EN
  logic [GEN_W-1:0] gen_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)            gen_cnt_reg <= '0;
    else if (last_xfer) gen_cnt_reg <= gen_cnt_reg + GEN_W'(1);
  end

  assign generation_o = gen_cnt_reg;
`else
  assign generation_o = '0;
`endif

endmodule

// File: tb/tb_sweep_scheduler.sv
// Scoreboard bench for sweep_scheduler: expected cells are queued by the stimulus, popped by a monitor.
module tb_sweep_scheduler;
  localparam int RES_W = 9, SPEED_W = 12, PRESCALE = 4, GEN_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               game_active = 1'b0;
  logic               cell_ready = 1'b1;
  logic [RES_W-1:0]   resolution = 9'd3;
  logic [SPEED_W-1:0] speed = 12'd2;
  logic               cell_valid, cell_last, busy;
  logic [RES_W-1:0]   cell_x, cell_y;
  logic [GEN_W-1:0]   generation;

  always #5 clk = ~clk;

  sweep_scheduler #(.RES_W(RES_W), .SPEED_W(SPEED_W), .PRESCALE(PRESCALE), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .game_active_i(game_active), .resolution_i(resolution),
    .speed_i(speed), .cell_valid_o(cell_valid), .cell_ready_i(cell_ready),
    .cell_x_o(cell_x), .cell_y_o(cell_y), .cell_last_o(cell_last),
    .generation_o(generation), .busy_o(busy)
  );

  typedef struct packed {
    logic [RES_W-1:0] x;
    logic [RES_W-1:0] y;
    logic             last;
  } cell_t;

  cell_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_gen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int n, input int count);
    int ne;
    cell_t c;
    ne = (n == 0) ? 1 : n;
    for (int i = 0; i < count; i++) begin
      c.x = RES_W'(i % ne);
      c.y = RES_W'(i / ne);
      c.last = (i == ne * ne - 1);
      exp_q.push_back(c);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts busy-but-not-valid cycles until the first valid cell, returning at that negedge.
  task automatic wait_sweep(input int exp_len);
    int cnt;
    bit ok;
    cnt = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cell_valid) begin
        ok = 1;
        break;
      end
      if (busy) cnt++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_timeout: got no cell_valid expected one within 400 cycles");
    end
    check("wait_len", cnt, exp_len);
  endtask

  // Runs until the scoreboard is empty, returning 1 time unit after the edge following the last transfer.
  task automatic drain(input bit toggle);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      if (toggle) cell_ready = ~cell_ready;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cells pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, cell_valid, 0);
    check({tag, "_x"}, cell_x, 0);
    check({tag, "_y"}, cell_y, 0);
    check({tag, "_last"}, cell_last, 0);
    check({tag, "_gen"}, generation, exp_gen);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic bump_gen();
`ifdef SWEEP_GEN_COUNT_EN
    exp_gen++;
`endif
  endtask

  // Monitor: pops the scoreboard on every transfer and checks that stalled cells hold stable.
  bit    hold_pending = 0;
  cell_t held;
  always @(negedge clk) begin
    cell_t got, e;
    got = {cell_x, cell_y, cell_last};
    if (hold_pending) begin
      check("hold_valid", cell_valid, 1);
      check("hold_cell", got, held);
    end
    hold_pending = 0;
    if (cell_valid && cell_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_xfer: got (%0d,%0d) expected no transfer", cell_x, cell_y);
      end else begin
        e = exp_q.pop_front();
        $display("xfer (%0d,%0d) last=%0d expected (%0d,%0d) last=%0d",
                 cell_x, cell_y, cell_last, e.x, e.y, e.last);
        check("cell", got, e);
      end
    end else if (cell_valid) begin
      hold_pending = 1;
      held = got;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit found;

    step(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    step(1);

    // Basic sweep, ready tied high
    resolution = 9'd3; speed = 12'd2; cell_ready = 1'b1;
    push_frame(3, 9);
    game_active = 1'b1;
    wait_sweep(12);
    drain(0);
    bump_gen();
    check("t1_gen", generation, exp_gen);
    check("t1_valid_after", cell_valid, 0);
    check("t1_busy_after", busy, 1);

    // Enable drop during the following WAIT
    step(3);
    check("t1w_busy", busy, 1);
    game_active = 1'b0;
    step(1);
    check("t1w_busy_drop", busy, 0);
    check("t1w_gen", generation, exp_gen);
    step(20);
    check("t1w_still_idle", busy, 0);

    // Ready toggling, with mid-sweep parameter changes ignored
    push_frame(3, 9);
    game_active = 1'b1;
    wait_sweep(12);
    resolution = 9'd5; speed = 12'd7;
    drain(1);
    cell_ready = 1'b1;
    bump_gen();
    check("t2_gen", generation, exp_gen);
    game_active = 1'b0;
    step(1);
    check("t2_busy_idle", busy, 0);

    // Enable drop at the 4th transfer: frame still completes
    resolution = 9'd3; speed = 12'd1;
    push_frame(3, 9);
    game_active = 1'b1;
    wait_sweep(8);
    n = 1;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (cell_valid && cell_ready) n++;
    end
    game_active = 1'b0;
    drain(0);
    bump_gen();
    check("t3_gen", generation, exp_gen);
    check("t3_busy", busy, 0);
    check("t3_valid", cell_valid, 0);

    // Resolution 0 clamps to a single cell, speed 0 waits PRESCALE cycles
    resolution = 9'd0; speed = 12'd0;
    push_frame(0, 1);
    game_active = 1'b1;
    wait_sweep(4);
    drain(0);
    bump_gen();
    check("t4_gen", generation, exp_gen);
    check("t4_busy", busy, 1);
    game_active = 1'b0;
    step(1);
    check("t4_busy_idle", busy, 0);

    // Reset mid-sweep at cell (1,1)
    resolution = 9'd3; speed = 12'd0;
    push_frame(3, 5);
    game_active = 1'b1;
    wait_sweep(4);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (cell_valid && cell_x == 9'd1 && cell_y == 9'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("t5_reached_1_1", found, 1);
    rst = 1'b1;
    game_active = 1'b0;
    step(1);
    exp_gen = 0;
    check_idle_outputs("t5_rst");
    check("t5_queue_empty", exp_q.size(), 0);
    rst = 1'b0;
    step(5);
    check("t5_idle_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
